// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain
//
// Purpose:
//   Read-side scheduler that drains NCH FIFO read ports into a single
//   valid/ready byte stream. Each output byte is tagged with its source
//   channel. The FIFOs have a 1-cycle registered rd_data.
//
//   Channels are granted round-robin. Each grant may pop up to BURST_MAX
//   times before the scheduler rotates to the next channel. Everything runs
//   in the FIFO read clock domain.
//
// Ports:
//   rd_clk        clock (same as the FIFO read clock)
//   rd_rst        synchronous reset, active-high
//   enable        0: start no new grant, and end the current burst at the
//                 next issue slot
//   chan_mask     per-channel grant eligibility
//   fifo_empty    per-channel empty flags
//   fifo_rd_en    per-channel pop strobes (at most one high per cycle)
//   fifo_rd_data  packed read data; channel i is at [i*DW +: DW]
//   out_valid     out_data/out_chan are valid
//   out_ready     downstream accept
//   out_data      popped byte
//   out_chan      source channel of out_data
//   busy          FSM in BURST, a read in flight, or output buffer occupied
//
// Optional feature:
//   FIFO_DRAIN_STATS_EN  when defined, adds two free-running counters, both
//                        cleared by rd_rst:
//                          stat_bytes  - one count per pop
//                          stat_grants - one count per IDLE->BURST transition
//
// Reset note:
//   A reset in the middle of a burst discards any in-flight or buffered
//   bytes. The FIFO read pointers have already advanced past them, so those
//   bytes are lost.

module fifo_rr_drain #(
  parameter int NCH       = 4,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic                     enable,
  input  logic [NCH-1:0]           chan_mask,
  input  logic [NCH-1:0]           fifo_empty,
  output logic [NCH-1:0]           fifo_rd_en,
  input  logic [NCH*DW-1:0]        fifo_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(NCH)-1:0]   out_chan,
`ifdef FIFO_DRAIN_STATS_EN
  output logic [31:0]              stat_bytes,
  output logic [15:0]              stat_grants,
`endif
  output logic                     busy
);

  localparam int CW = $clog2(NCH);
  localparam logic [CW:0]   NCH_W   = (CW+1)'(NCH);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);
  localparam logic [7:0]    BMAX    = 8'(BURST_MAX);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          infl_q;
  logic [CW-1:0] infl_chan_q;
  logic [1:0]    occ_q;
  logic [DW-1:0] buf0_data_q, buf1_data_q;
  logic [CW-1:0] buf0_chan_q, buf1_chan_q;

  logic          out_pop;
  logic [2:0]    pending;
  logic          credit;
  logic          pop_en;
  logic          scan_found;
  logic [CW-1:0] scan_pick;
  logic [CW:0]   scan_idx;
  logic [CW-1:0] grant_inc;
  logic [DW-1:0] rd_data_arr [NCH];
  logic [DW-1:0] wr_data;

  // Unpack the read data bus and build the one-hot pop strobes.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign rd_data_arr[gi] = fifo_rd_data[gi*DW +: DW];
    assign fifo_rd_en[gi]  = pop_en && (grant_q == CW'(gi));
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_pop   = out_valid && out_ready;
  assign out_data  = buf0_data_q;
  assign out_chan  = buf0_chan_q;
  assign busy      = (state_q != S_IDLE) || infl_q || (occ_q != 2'd0);
  assign wr_data   = rd_data_arr[infl_chan_q];

  // Bytes that will still need a buffer slot after this cycle. Keeping this
  // at or below 1 before issuing a pop is what bounds the buffer at 2 entries.
  assign pending = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, out_pop};
  assign credit  = (pending <= 3'd1);

  // Explicit compare, so non-power-of-2 NCH wraps correctly.
  assign grant_inc = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;

  // Round-robin scan: first eligible, non-empty channel at or after rr_ptr.
  always_comb begin
    scan_found = 1'b0;
    scan_pick  = '0;
    scan_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (CW+1)'(k);
      if (scan_idx >= NCH_W) begin
        scan_idx = scan_idx - NCH_W;
      end
      if (!scan_found && chan_mask[scan_idx[CW-1:0]] &&
          !fifo_empty[scan_idx[CW-1:0]]) begin
        scan_found = 1'b1;
        scan_pick  = scan_idx[CW-1:0];
      end
    end
  end

  // Grant / burst FSM.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    pop_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && scan_found) begin
          grant_d = scan_pick;
          cnt_d   = 8'd0;
          state_d = S_BURST;
        end
      end
      default: begin
        // Without credit, hold: no pop, count unchanged, grant kept.
        if (credit) begin
          if (!fifo_empty[grant_q] && chan_mask[grant_q] && enable) begin
            pop_en = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == BMAX) begin
              state_d  = S_IDLE;
              rr_ptr_d = grant_inc;
            end
          end else begin
            state_d  = S_IDLE;
            rr_ptr_d = grant_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // In-flight tracker. rd_data is valid one cycle after the pop.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      infl_q      <= 1'b0;
      infl_chan_q <= '0;
    end else begin
      infl_q      <= pop_en;
      infl_chan_q <= grant_q;
    end
  end

  // Two-entry output buffer. Entry 0 is the head and drives out_*.
  // A write with no pop while occ==2 cannot happen, because of the credit
  // check above.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      occ_q       <= 2'd0;
      buf0_data_q <= '0;
      buf0_chan_q <= '0;
      buf1_data_q <= '0;
      buf1_chan_q <= '0;
    end else if (out_pop) begin
      if (occ_q == 2'd2) begin
        buf0_data_q <= buf1_data_q;
        buf0_chan_q <= buf1_chan_q;
        if (infl_q) begin
          buf1_data_q <= wr_data;
          buf1_chan_q <= infl_chan_q;
        end else begin
          occ_q <= 2'd1;
        end
      end else begin
        if (infl_q) begin
          buf0_data_q <= wr_data;
          buf0_chan_q <= infl_chan_q;
        end else begin
          occ_q <= 2'd0;
        end
      end
    end else if (infl_q) begin
      if (occ_q == 2'd0) begin
        buf0_data_q <= wr_data;
        buf0_chan_q <= infl_chan_q;
        occ_q       <= 2'd1;
      end else begin
        buf1_data_q <= wr_data;
        buf1_chan_q <= infl_chan_q;
        occ_q       <= 2'd2;
      end
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] stat_bytes_q;
  logic [15:0] stat_grants_q;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      stat_bytes_q  <= 32'd0;
      stat_grants_q <= 16'd0;
    end else begin
      if (pop_en) begin
        stat_bytes_q <= stat_bytes_q + 32'd1;
      end
      if (state_q == S_IDLE && state_d == S_BURST) begin
        stat_grants_q <= stat_grants_q + 16'd1;
      end
    end
  end

  assign stat_bytes  = stat_bytes_q;
  assign stat_grants = stat_grants_q;
`endif

endmodule
